btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Front end for the guess-checking game logic. Synchronises the raw push-button and the 4 slide switches, then debounces
//  the button with a 4-state FSM. Emits exactly one 1-cycle btn_pulse per accepted press, and freezes the switch value
//  captured at that press, so the downstream stage needs no edge detection of its own.
// PARAMETERS
//  SYNC_STAGES      2            synchroniser flops on btn_raw and sw_raw (>=2)
//  DEBOUNCE_CYCLES  1_000_000    cycles a level must hold stable to be accepted (10 ms @ 100 MHz)
//  LONG_CYCLES      200_000_000  cycles held after acceptance before long_press (LONG_PRESS_EN only)
//  SW_W             4            switch bus width
// PORTS
//  clk         in   1     system clock, all logic on rising edge
//  rst_n       in   1     synchronous reset, active-low; sampled on rising clk edge only
//  btn_raw     in   1     asynchronous, bouncing push-button, active-high
//  sw_raw      in   SW_W  asynchronous slide switches (player guess)
//  btn_pulse   out  1     1-cycle strobe on each accepted press
//  sw_latched  out  SW_W  synchronised sw sampled in the same cycle btn_pulse is raised; held until next press
//  btn_level   out  1     debounced button level (1 in HELD/RELEASE_WAIT)
//  long_press  out  1     1-cycle strobe when held LONG_CYCLES (tied 0 without LONG_PRESS_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, counters=0, sync chains=0, btn_pulse=0, sw_latched=0, btn_level=0,
//    long_press=0. Reset mid-press wins over every other event; the press is lost, no pulse is emitted afterwards.
//  - btn_s / sw_s = last stage of the SYNC_STAGES chains. Raw-to-btn_s latency = SYNC_STAGES cycles.
//  - Counter cnt, width $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1). Saturates; never wraps.
//  - FSM:
//    IDLE:         btn_s=1 -> PRESS_WAIT, cnt=0.
//    PRESS_WAIT:   btn_s=0 -> IDLE (bounce rejected, no pulse). Else cnt++.
//                  At cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD, and in that same edge btn_pulse<=1, sw_latched<=sw_s.
//    HELD:         btn_s=0 -> RELEASE_WAIT, cnt=0.
//    RELEASE_WAIT: btn_s=1 -> HELD (release bounce ignored, no new pulse). Else cnt++.
//                  At cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//  - Press latency: btn_pulse asserts SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean rising edge on btn_raw.
//  - btn_pulse is high exactly 1 cycle. At most one pulse per IDLE->HELD transition; holding never re-pulses.
//  - sw changes while held or idle do not alter sw_latched.
//  - DEBOUNCE_CYCLES==1: a single stable synchronised sample is accepted (PRESS_WAIT lasts 1 cycle).
// CONFIGURATION
//  LONG_PRESS_EN defined:
//    - In HELD, a second counter hcnt (cleared on HELD entry from PRESS_WAIT only) counts to LONG_CYCLES-1.
//    - At that count long_press pulses 1 cycle, then hcnt saturates; exactly one long_press per hold.
//    - Excursions HELD->RELEASE_WAIT->HELD do not clear hcnt. Intended as the game's round-restart request.
//  LONG_PRESS_EN undefined:
//    - long_press is driven constant 0; no hcnt flops are synthesised.
// STRUCTURE
//  - Shared package/header game_defs.vh:
//      - localparam state encodings ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_HELD=2'd2, ST_RELEASE_WAIT=2'd3
//      - SW_W, and the 100 MHz clock constant used to derive DEBOUNCE_CYCLES
//  - One sub-module: sync_chain #(.W,.STAGES); plain flop chain, reset to 0 by rst_n. Instanced for btn and for sw.
//  - The FSM, counters and output registers live in btn_conditioner.
// TESTING (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=32, SYNC_STAGES=2)
//  1 Clean press: sw_raw=4'h9, btn_raw 0->1 held 40 cycles -> single btn_pulse exactly 10 cycles after edge,
//    sw_latched=4'h9, btn_level=1.
//  2 Bounce: btn_raw toggles 1,0,1,0 with 3-cycle high periods, then stable 1 -> no pulse during bouncing;
//    exactly one pulse 10 cycles after the final rising edge.
//  3 Release bounce: while HELD, btn_raw drops for 3 cycles then returns to 1 -> btn_level stays 1,
//    no second btn_pulse; clean release -> IDLE after 8 stable-low synchronised cycles.
//  4 Switch freeze: press with sw=4'h3, then change sw to 4'hC while held -> sw_latched stays 4'h3;
//    next press latches 4'hC.
//  5 Reset mid-op: assert rst_n=0 in PRESS_WAIT (cnt=5) for 1 cycle -> all outputs 0 next cycle;
//    no pulse until a fresh 10-cycle press.
//  6 LONG_PRESS_EN: hold 60 cycles -> long_press 1-cycle strobe 32 cycles after btn_pulse, only once;
//    without macro long_press stays 0 throughout.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button front end: FSM state encodings, switch width and clock-derived timing defaults.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int SW_WIDTH            = 4;
    localparam int CLK_HZ              = 100_000_000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYCLES_DEF     = 200_000_000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_sync_chain.sv
// Plain flop chain that brings an asynchronous bus into the clk domain; every stage clears on rst_n.
module btn_conditioner_sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= d_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= stage_q[gi-1];
                end
            end
        end
    endgenerate

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises and debounces a push-button, emitting one strobe per accepted press with the switch value frozen at it.
// Optional hold detector enabled by defining LONG_PRESS_EN.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int SW_W            = SW_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic            btn_pulse,
    output logic [SW_W-1:0] sw_latched,
    output logic            btn_level,
    output logic            long_press
);

    localparam int            CNT_W   = $clog2(max2(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic            btn_s;
    logic [SW_W-1:0] sw_s;

    btn_conditioner_sync_chain #(.W(1), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_raw),
        .q_o   (btn_s)
    );

    btn_conditioner_sync_chain #(.W(SW_W), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw_raw),
        .q_o   (sw_s)
    );

    btn_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic            btn_pulse_q;
    logic [SW_W-1:0] sw_latched_q;
    logic            btn_level_q;
    logic            press_accept;

    assign cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign press_accept = (state_q == ST_PRESS_WAIT) && btn_s && (cnt_q == DB_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            btn_pulse_q  <= 1'b0;
            sw_latched_q <= '0;
            btn_level_q  <= 1'b0;
        end else begin
            btn_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (btn_s) begin
                        state_q <= ST_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= ST_IDLE;
                    end else if (press_accept) begin
                        state_q      <= ST_HELD;
                        btn_pulse_q  <= 1'b1;
                        sw_latched_q <= sw_s;
                        btn_level_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HELD: begin
                    if (!btn_s) begin
                        state_q <= ST_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A high sample here is release bounce: back to HELD without a new strobe.
                    if (btn_s) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == DB_LAST) begin
                        state_q     <= ST_IDLE;
                        btn_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign btn_pulse  = btn_pulse_q;
    assign sw_latched = sw_latched_q;
    assign btn_level  = btn_level_q;

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hcnt_q;
    logic             long_press_q;

    // hcnt only counts while the button is genuinely held; parking at LONG_SAT gives one strobe per hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q       <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_press_q <= 1'b0;
            if (press_accept) begin
                hcnt_q <= '0;
            end else if ((state_q == ST_HELD) && btn_s) begin
                if (hcnt_q == LONG_LAST) begin
                    long_press_q <= 1'b1;
                    hcnt_q       <= LONG_SAT;
                end else if (hcnt_q != LONG_SAT) begin
                    hcnt_q <= hcnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/long-press timings.
module tb_btn_conditioner;

    // Raw edge applied after posedge C is sampled at C+1; strobe visible after posedge C+1+SYNC+DEBOUNCE = C+11.
    localparam int LAT      = 11;
    localparam int LONG_LAT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       btn_pulse;
    logic [3:0] sw_latched;
    logic       btn_level;
    logic       long_press;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_long;
        int         cyc;
        logic [3:0] sw;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    btn_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .SW_W            (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .btn_pulse  (btn_pulse),
        .sw_latched (sw_latched),
        .btn_level  (btn_level),
        .long_press (long_press)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_event(input bit is_long);
        ev_t e;
        $display("[TB] cycle %0d %s sw_latched=%h btn_level=%0b", cyc,
                 is_long ? "long_press" : "btn_pulse", sw_latched, btn_level);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none",
                     is_long ? "long_press" : "btn_pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_long), 32'(e.is_long));
            check("event_cycle", cyc, e.cyc);
            if (!is_long) begin
                check("sw_latched_at_pulse", 32'(sw_latched), 32'(e.sw));
                check("btn_level_at_pulse", 32'(btn_level), 32'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (btn_pulse) on_event(1'b0);
        if (long_press) on_event(1'b1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] sw);
        ev_t e;
        sw_raw  = sw;
        btn_raw = 1'b1;
        e.is_long = 1'b0;
        e.cyc     = cyc + LAT;
        e.sw      = sw;
        exp_q.push_back(e);
    endtask

    task automatic release_and_check_idle(input string name);
        btn_raw = 1'b0;
        wait_cyc(LAT - 1);
        check({name, "_level_before_idle"}, 32'(btn_level), 32'd1);
        wait_cyc(1);
        check({name, "_level_idle"}, 32'(btn_level), 32'd0);
    endtask

    initial begin
        ev_t le;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = 4'h0;
        wait_cyc(3);
        check("reset_btn_pulse", 32'(btn_pulse), 32'd0);
        check("reset_btn_level", 32'(btn_level), 32'd0);
        check("reset_sw_latched", 32'(sw_latched), 32'd0);
        check("reset_long_press", 32'(long_press), 32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press
        press(4'h9);
        wait_cyc(LAT - 1);
        check("t1_level_before_accept", 32'(btn_level), 32'd0);
        wait_cyc(1);
        check("t1_level_after_accept", 32'(btn_level), 32'd1);
        wait_cyc(40 - LAT);
        release_and_check_idle("t1");
        check("t1_sw_latched_hold", 32'(sw_latched), 32'h9);
        wait_cyc(3);

        // Press bounce: two short highs are rejected
        sw_raw = 4'h5;
        for (int i = 0; i < 2; i++) begin
            btn_raw = 1'b1;
            wait_cyc(3);
            btn_raw = 1'b0;
            wait_cyc(3);
        end
        check("t2_level_after_bounce", 32'(btn_level), 32'd0);
        press(4'h5);
        wait_cyc(LAT + 15);
        release_and_check_idle("t2");
        wait_cyc(3);

        // Release bounce while held
        press(4'h6);
        wait_cyc(20);
        btn_raw = 1'b0;
        wait_cyc(3);
        btn_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_cyc(1);
            check("t3_level_through_bounce", 32'(btn_level), 32'd1);
        end
        release_and_check_idle("t3");
        wait_cyc(3);

        // Switch freeze
        press(4'h3);
        wait_cyc(LAT + 4);
        sw_raw = 4'hC;
        wait_cyc(10);
        check("t4_sw_frozen_held", 32'(sw_latched), 32'h3);
        release_and_check_idle("t4");
        wait_cyc(4);
        check("t4_sw_frozen_idle", 32'(sw_latched), 32'h3);
        press(4'hC);
        wait_cyc(LAT + 5);
        release_and_check_idle("t4b");
        wait_cyc(3);

        // Reset while in PRESS_WAIT with cnt=5; button stays high
        sw_raw  = 4'h7;
        btn_raw = 1'b1;
        wait_cyc(8);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        check("t5_rst_btn_pulse", 32'(btn_pulse), 32'd0);
        check("t5_rst_btn_level", 32'(btn_level), 32'd0);
        check("t5_rst_sw_latched", 32'(sw_latched), 32'd0);
        check("t5_rst_long_press", 32'(long_press), 32'd0);
        // Sync chain restarts from 0 at the reset edge, so the press is re-timed from here
        press(4'h7);
        wait_cyc(LAT + 10);
        release_and_check_idle("t5");
        wait_cyc(3);

        // Long hold
        press(4'hA);
`ifdef LONG_PRESS_EN
        le.is_long = 1'b1;
        le.cyc     = cyc + LAT + LONG_LAT;
        le.sw      = 4'h0;
        exp_q.push_back(le);
`else
        le.is_long = 1'b0;
        le.cyc     = 0;
        le.sw      = 4'h0;
`endif
        wait_cyc(60);
        release_and_check_idle("t6");
        check("t6_sw_latched", 32'(sw_latched), 32'hA);
        wait_cyc(5);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
